// File: rtl/spike_rate_decoder_if.sv
// spike_rate_decoder_if: word-addressed memory bus between a host and the spike rate decoder
interface spike_rate_decoder_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_wen;
   logic [DATA_WIDTH-1:0] mem_data_in;
   logic [DATA_WIDTH-1:0] mem_data_out;
   modport master (output mem_addr, mem_wen, mem_data_in, input mem_data_out);
   modport slave (input mem_addr, mem_wen, mem_data_in, output mem_data_out);
endinterface

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: per-channel spike counting over a window, then a sequential scan for the most active channel
module spike_rate_decoder #(
   parameter int NUM_SPIKES  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   spike_rate_decoder_if.slave   bus,
   input  logic [NUM_SPIKES-1:0] spikes_in,
   output logic                  busy,
   output logic                  done
);
   localparam int IW = NUM_SPIKES > 1 ? $clog2(NUM_SPIKES) : 1;
   typedef enum logic [1:0] {IDLE, COUNT, SCAN, DONE} state_t;
   state_t                 state_q, state_d;
   logic [15:0]            window_r, win_left;
   logic [COUNT_WIDTH-1:0] cnt [NUM_SPIKES];
   logic [COUNT_WIDTH-1:0] win_cnt;
   logic [IW-1:0]          win_idx, scan_idx;
   logic [ADDR_WIDTH-1:0]  cnt_off;
   logic [DATA_WIDTH-1:0]  rd_val;
   logic                   wr_ctrl, abort, start, last;
   // Control decode and next state; abort outranks start, start is only honoured when not busy
   always_comb begin
      wr_ctrl = bus.mem_wen && bus.mem_addr == '0;
      abort   = wr_ctrl && bus.mem_data_in[1];
      start   = wr_ctrl && bus.mem_data_in[0] && !bus.mem_data_in[1] && (state_q == IDLE || state_q == DONE);
      last    = scan_idx == IW'(NUM_SPIKES - 1);
      state_d = abort ? IDLE :
                start ? (window_r == '0 ? SCAN : COUNT) :
                (state_q == COUNT && win_left == 16'd1) ? SCAN :
                (state_q == SCAN && last) ? DONE : state_q;
   end
   // Read mux; counter window sits at 0x20 and is bounded by the channel count
   always_comb begin
      cnt_off = bus.mem_addr - ADDR_WIDTH'(32);
      rd_val  = bus.mem_addr == ADDR_WIDTH'(1) ? DATA_WIDTH'(window_r) :
                bus.mem_addr == ADDR_WIDTH'(2) ? DATA_WIDTH'({done, busy}) :
                bus.mem_addr == ADDR_WIDTH'(3) ? DATA_WIDTH'(win_idx) :
                bus.mem_addr == ADDR_WIDTH'(4) ? DATA_WIDTH'(win_cnt) :
                (bus.mem_addr >= ADDR_WIDTH'(32) && cnt_off < ADDR_WIDTH'(NUM_SPIKES)) ? DATA_WIDTH'(cnt[cnt_off[IW-1:0]]) : '0;
   end
   // State register with busy/done registered from the next state so they never overlap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         busy    <= state_d == COUNT || state_d == SCAN;
         done    <= state_d == DONE;
      end
   end
   // Registered read data, one cycle after the address is sampled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) bus.mem_data_out <= '0;
      else bus.mem_data_out <= rd_val;
   end
   // Window register, saturating counters and the winner scan
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         window_r <= 16'd256;
         win_left <= '0;
         scan_idx <= '0;
         win_idx  <= '0;
         win_cnt  <= '0;
         for (int i = 0; i < NUM_SPIKES; i++) cnt[i] <= '0;
      end else begin
         if (bus.mem_wen && bus.mem_addr == ADDR_WIDTH'(1)) window_r <= bus.mem_data_in[15:0];
         if (abort || start) begin
            win_left <= window_r;
            scan_idx <= '0;
            win_idx  <= '0;
            win_cnt  <= '0;
            for (int i = 0; i < NUM_SPIKES; i++) cnt[i] <= '0;
         end else if (state_q == COUNT) begin
            for (int i = 0; i < NUM_SPIKES; i++) cnt[i] <= (spikes_in[i] && cnt[i] != '1) ? cnt[i] + 1'b1 : cnt[i];
            win_left <= win_left - 1'b1;
         end else if (state_q == SCAN) begin
            if (scan_idx == '0 || cnt[scan_idx] > win_cnt) begin
               win_idx <= scan_idx;
               win_cnt <= cnt[scan_idx];
            end
            scan_idx <= scan_idx + 1'b1;
         end
      end
   end
endmodule
